// File: rtl/mux_nto1_stream_pkg.sv
// Shared constants and helpers for the N-to-1 stream selector.
package mux_pkg;

   localparam logic MODE_STATIC = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // Width of a channel index for n channels (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_nto1_stream_if.sv
// Handshake bundle between the producers/consumer and the stream selector.
interface mux_nto1_stream_if
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4
);
   localparam int unsigned SELW = idx_width(N);

   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [N-1:0]         in_valid;
   logic [N*WIDTH-1:0]   in_data;
   logic [N-1:0]         in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_ready;

   // Producer/consumer side.
   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   // Selector side.
   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );

endinterface

// File: rtl/mux_nto1_stream_arb.sv
// Combinational rotating-priority arbiter: the first request at or after ptr wins.
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = idx_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_vld,
   output logic [SELW-1:0] gnt_idx
);

   localparam int unsigned SW1 = SELW + 1;

   logic [N-1:0]    rot_c;
   logic [SELW-1:0] off_c;
   logic [SW1-1:0]  sum_c;

   // Rotate requests so that the channel at ptr lands on bit 0.
   always_comb begin
      rot_c = N'({req, req} >> ptr);
   end

   // Lowest set bit of the rotated vector is the winning offset.
   always_comb begin
      gnt_vld = 1'b0;
      off_c   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot_c[j]) begin
            gnt_vld = 1'b1;
            off_c   = SELW'(j);
         end
      end
   end

   // Map the offset back to an absolute channel index, wrapping at N.
   always_comb begin
      sum_c = {1'b0, ptr} + {1'b0, off_c};
      if (sum_c >= SW1'(N)) begin
         sum_c = sum_c - SW1'(N);
      end
      gnt_idx = sum_c[SELW-1:0];
   end

endmodule

// File: rtl/mux_nto1_stream.sv
// Registered N-to-1 stream selector with static and round-robin channel selection.
module mux_nto1_stream
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   mux_nto1_stream_if.slave bus
);

   localparam int unsigned SELW = idx_width(N);

   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q,  out_data_d;
   logic [SELW-1:0]      out_ch_q,    out_ch_d;
   logic [SELW-1:0]      ptr_q,       ptr_d;

   logic                 can_load_c;
   logic                 st_vld_c;
   logic                 rr_vld_c;
   logic [SELW-1:0]      rr_idx_c;
   logic                 grant_vld_c;
   logic [SELW-1:0]      grant_idx_c;
   logic [WIDTH-1:0]     grant_data_c;
   logic                 load_c;
   logic [N-1:0]         in_ready_c;

   mux_rr_arb #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req     (bus.in_valid),
      .ptr     (ptr_q),
      .gnt_vld (rr_vld_c),
      .gnt_idx (rr_idx_c)
   );

   // Output slot can take a new word when empty or draining this cycle.
   always_comb begin
      can_load_c = !out_valid_q || bus.out_ready;
   end

   // Static grant; an out-of-range sel matches no channel and so never grants.
   always_comb begin
      st_vld_c = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((SELW'(i) == bus.sel) && bus.in_valid[i]) begin
            st_vld_c = 1'b1;
         end
      end
   end

   // Pick the active grant source for the current mode.
   always_comb begin
      if (bus.mode == MODE_RR) begin
         grant_vld_c = rr_vld_c;
         grant_idx_c = rr_idx_c;
      end else begin
         grant_vld_c = st_vld_c;
         grant_idx_c = bus.sel;
      end
      load_c = can_load_c && grant_vld_c;
   end

   // Data mux and one-hot ready for the granted channel.
   always_comb begin
      grant_data_c = '0;
      in_ready_c   = '0;
      for (int i = 0; i < N; i++) begin
         if (SELW'(i) == grant_idx_c) begin
            grant_data_c  = bus.in_data[i*WIDTH +: WIDTH];
            in_ready_c[i] = load_c;
         end
      end
   end

   // Next state of the output buffer and round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (load_c) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data_c;
         out_ch_d    = grant_idx_c;
         if (bus.mode == MODE_RR) begin
            ptr_d = (grant_idx_c == SELW'(N - 1)) ? '0 : grant_idx_c + SELW'(1);
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any buffered word and rewinds the pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: directed scenarios plus random traffic against a reference model.
module tb_mux_nto1_stream;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned N5 = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_nto1_stream_if #(.WIDTH(W), .N(N))  bus  ();
   mux_nto1_stream_if #(.WIDTH(W), .N(N5)) bus5 ();

   mux_nto1_stream #(.WIDTH(W), .N(N))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   mux_nto1_stream #(.WIDTH(W), .N(N5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

   int n_vec = 0;
   int n_err = 0;

   // Reference model of the output slot and round-robin pointer.
   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_ch;
   int           m_ptr;

   // Which channel the rules grant right now (ignoring output occupancy).
   function automatic void ref_grant(output bit v, output int idx);
      v   = 1'b0;
      idx = 0;
      if (bus.mode == 1'b0) begin
         idx = int'(bus.sel);
         v   = (idx < N) && bus.in_valid[idx];
      end else begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!v && bus.in_valid[c]) begin
               v   = 1'b1;
               idx = c;
            end
         end
      end
   endfunction

   function automatic logic [N-1:0] ref_ready();
      bit           v;
      int           idx;
      logic [N-1:0] r;
      r = '0;
      ref_grant(v, idx);
      if ((!m_valid || bus.out_ready) && v) r[idx] = 1'b1;
      return r;
   endfunction

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      bit v;
      int idx;
      bit can;
      ref_grant(v, idx);
      can = !m_valid || bus.out_ready;
      @(posedge clk);
      if (rst_n) begin
         if (can && v) begin
            m_valid = 1'b1;
            m_data  = bus.in_data[idx*W +: W];
            m_ch    = idx;
            if (bus.mode) m_ptr = (idx + 1) % N;
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.mode      = 1'b0;
      bus.sel       = '0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus5.mode      = 1'b0;
      bus5.sel       = '0;
      bus5.in_valid  = '0;
      bus5.in_data   = '0;
      bus5.out_ready = 1'b1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_data_index();
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'(i);
   endtask

   task automatic test_reset();
      apply_reset();
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      n_vec++;
      if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
      n_vec++;
      if (bus.out_ch !== 2'd0) begin n_err++; $display("FAIL reset_out_ch got %0d exp 0", bus.out_ch); end
      n_vec++;
      if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready got %b exp 0000", bus.in_ready); end
      n_vec++;
      // Load a word, then drop reset between edges.
      bus.mode = 1'b1;
      bus.in_valid = 4'b1111;
      bus.in_data = 32'h44332211;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_ch !== 2'd0) begin
         n_err++;
         $display("FAIL async_reset got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", bus.out_valid, bus.out_data, bus.out_ch);
      end
      n_vec++;
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      if (bus.in_ready !== 4'b0001) begin n_err++; $display("FAIL post_reset_ready got %b exp 0001", bus.in_ready); end
      n_vec++;
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 8'h11) begin
         n_err++;
         $display("FAIL post_reset_first got v=%b ch=%0d d=%h exp v=1 ch=0 d=11", bus.out_valid, bus.out_ch, bus.out_data);
      end
      n_vec++;
   endtask

   task automatic test_static();
      apply_reset();
      bus.mode = 1'b0;
      bus.sel = 2'd2;
      bus.in_valid = 4'b1111;
      bus.in_data = {8'h3C, 8'hA5, 8'h5A, 8'h0F};
      #1;
      if (bus.in_ready !== 4'b0100) begin n_err++; $display("FAIL static_ready got %b exp 0100", bus.in_ready); end
      n_vec++;
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_ch !== 2'd2) begin
         n_err++;
         $display("FAIL static_out got v=%b d=%h ch=%0d exp v=1 d=a5 ch=2", bus.out_valid, bus.out_data, bus.out_ch);
      end
      n_vec++;
      // Out-of-range select on a five-channel instance.
      bus5.mode = 1'b0;
      bus5.sel = 3'd5;
      bus5.in_valid = 5'b11111;
      bus5.in_data = 40'h5544332211;
      #1;
      if (bus5.in_ready !== 5'b00000) begin n_err++; $display("FAIL static_oor_ready got %b exp 00000", bus5.in_ready); end
      n_vec++;
      tick();
      if (bus5.out_valid !== 1'b0) begin n_err++; $display("FAIL static_oor_out got v=%b exp 0", bus5.out_valid); end
      n_vec++;
      bus5.sel = 3'd4;
      #1;
      if (bus5.in_ready !== 5'b10000) begin n_err++; $display("FAIL static_last_ready got %b exp 10000", bus5.in_ready); end
      n_vec++;
      tick();
      if (bus5.out_valid !== 1'b1 || bus5.out_ch !== 3'd4 || bus5.out_data !== 8'h55) begin
         n_err++;
         $display("FAIL static_last_out got v=%b ch=%0d d=%h exp v=1 ch=4 d=55", bus5.out_valid, bus5.out_ch, bus5.out_data);
      end
      n_vec++;
      bus5.in_valid = '0;
   endtask

   task automatic test_rr_fairness();
      apply_reset();
      bus.mode = 1'b1;
      bus.in_valid = 4'b1111;
      set_data_index();
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(k % N) || bus.out_data !== 8'(k % N)) begin
            n_err++;
            $display("FAIL rr_fair[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d", k, bus.out_valid, bus.out_ch, bus.out_data, k % N);
         end
         n_vec++;
      end
   endtask

   task automatic test_rr_skip();
      int exp_seq[4] = '{1, 3, 1, 3};
      apply_reset();
      bus.mode = 1'b1;
      bus.in_valid = 4'b1010;
      set_data_index();
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.out_ch !== 2'(exp_seq[k]) || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rr_skip[%0d] got v=%b ch=%0d exp v=1 ch=%0d", k, bus.out_valid, bus.out_ch, exp_seq[k]);
         end
         n_vec++;
      end
      bus.in_valid = 4'b0001;
      tick();
      if (bus.out_ch !== 2'd0 || bus.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rr_only0 got v=%b ch=%0d exp v=1 ch=0", bus.out_valid, bus.out_ch);
      end
      n_vec++;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] held;
      apply_reset();
      bus.mode = 1'b1;
      bus.in_valid = 4'b1111;
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'(8'h10 + i);
      tick();
      held = 8'h10;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d] got %b exp 0000", k, bus.in_ready); end
         n_vec++;
         tick();
         if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.out_ch !== 2'd0) begin
            n_err++;
            $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d exp v=1 d=%h ch=0", k, bus.out_valid, bus.out_data, bus.out_ch, held);
         end
         n_vec++;
      end
      bus.out_ready = 1'b1;
      #1;
      if (bus.in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready got %b exp 0010", bus.in_ready); end
      n_vec++;
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 8'h11) begin
         n_err++;
         $display("FAIL bp_release_out got v=%b ch=%0d d=%h exp v=1 ch=1 d=11", bus.out_valid, bus.out_ch, bus.out_data);
      end
      n_vec++;
   endtask

   task automatic test_mode_switch();
      apply_reset();
      bus.mode = 1'b1;
      bus.in_valid = 4'b1111;
      set_data_index();
      tick();
      tick();
      bus.mode = 1'b0;
      bus.sel = 2'd3;
      #1;
      if (bus.in_ready !== 4'b1000) begin n_err++; $display("FAIL mode_static_ready got %b exp 1000", bus.in_ready); end
      n_vec++;
      tick();
      if (bus.out_ch !== 2'd3) begin n_err++; $display("FAIL mode_static_out got ch=%0d exp 3", bus.out_ch); end
      n_vec++;
      bus.mode = 1'b1;
      #1;
      if (bus.in_ready !== 4'b0100) begin n_err++; $display("FAIL mode_rr_resume_ready got %b exp 0100", bus.in_ready); end
      n_vec++;
      tick();
      if (bus.out_ch !== 2'd2) begin n_err++; $display("FAIL mode_rr_resume_out got ch=%0d exp 2", bus.out_ch); end
      n_vec++;
   endtask

   task automatic test_random();
      logic [N-1:0] er;
      apply_reset();
      for (int k = 0; k < 300; k++) begin
         bus.mode      = 1'($urandom_range(0, 1));
         bus.sel       = 2'($urandom_range(0, N - 1));
         bus.in_valid  = 4'($urandom);
         bus.in_data   = 32'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         er = ref_ready();
         if (bus.in_ready !== er) begin n_err++; $display("FAIL rand_ready[%0d] got %b exp %b", k, bus.in_ready, er); end
         n_vec++;
         tick();
         if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_ch !== 2'(m_ch)) begin
            n_err++;
            $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d",
                     k, bus.out_valid, bus.out_data, bus.out_ch, m_valid, m_data, m_ch);
         end
         n_vec++;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_static();
      test_rr_fairness();
      test_rr_skip();
      test_backpressure();
      test_mode_switch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
